// File: rtl/phase_sequencer.sv
// Instruction-cycle controller: steps phases 0..4, strobes one-hot phase enables,
// and drives the fetch/load memory handshake with a bounded stall timeout.
module phase_sequencer #(
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_W     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       exec,
  input  logic       halt_req,
  input  logic       is_load,
  input  logic       is_input,
  input  logic       mem_ack,
  output logic [2:0] phase_counter,
  output logic [4:0] phase_en,
  output logic       op_mdr,
  output logic       mem_req,
  output logic       running,
  output logic       halted,
  output logic       error
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_HALT = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;
  localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(WAIT_LIMIT);

  logic [2:0]        state, state_nxt, phase_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt, cnt_inc;
  logic              stop_pending, stop_nxt, exec_q, exec_rise;
  logic              in_run, in_wait, adv;

  assign exec_rise = exec & ~exec_q;
  assign in_run    = (state == S_RUN);
  assign in_wait   = (state == S_WAIT);
  assign running   = in_run | in_wait;
  assign halted    = (state == S_HALT);
  assign error     = (state == S_ERR);
  assign cnt_inc   = wait_cnt + WAIT_W'(1);

  // IN wins over LD at phase 4; a request once stalled is held through WAIT.
  always_comb begin
    mem_req  = in_wait | (in_run & ((phase_counter == 3'd0) |
               ((phase_counter == 3'd4) & is_load & ~is_input)));
    op_mdr   = in_run & (phase_counter == 3'd4) & is_input;
    adv      = running & (~mem_req | mem_ack);
    phase_en = adv ? (5'b00001 << phase_counter) : 5'b00000;
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase_counter;
    wait_nxt  = wait_cnt;
    stop_nxt  = stop_pending;
    case (state)
      S_IDLE, S_HALT: begin
        if (exec_rise) begin
          state_nxt = S_RUN;
          phase_nxt = 3'd0;
          wait_nxt  = '0;
          stop_nxt  = 1'b0;
        end
      end
      S_RUN, S_WAIT: begin
        if (adv) begin
          wait_nxt = '0;
          if (phase_counter == 3'd4) begin
            phase_nxt = 3'd0;
            stop_nxt  = 1'b0;
            if (halt_req)                       state_nxt = S_HALT;
            else if (stop_pending || exec_rise) state_nxt = S_IDLE;
            else                                state_nxt = S_RUN;
          end else begin
            phase_nxt = phase_counter + 3'd1;
            state_nxt = S_RUN;
            stop_nxt  = stop_pending | exec_rise;
          end
        end else begin
          // Every un-acked request cycle counts as a stall.
          wait_nxt  = cnt_inc;
          stop_nxt  = stop_pending | exec_rise;
          state_nxt = (cnt_inc >= LIMIT) ? S_ERR : S_WAIT;
          if (cnt_inc >= LIMIT) stop_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      phase_counter <= 3'd0;
      wait_cnt      <= '0;
      stop_pending  <= 1'b0;
      exec_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase_counter <= phase_nxt;
      wait_cnt      <= wait_nxt;
      stop_pending  <= stop_nxt;
      exec_q        <= exec;
    end
  end

endmodule
